tx_fifo_ctrl: RTL and testbench

//  Single-clock controller that sequences a dp_ram instance as a TX FIFO.

---
 rtl/tx_fifo_ctrl_pkg.sv | 14 +
 rtl/tx_fifo_ptr.sv | 25 ++
 rtl/tx_fifo_ctrl.sv | 103 ++++++++++
 tb/tb_tx_fifo_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_ctrl_pkg.sv
// Shared defaults and types for the TX FIFO controller and its wrapper.
package tx_fifo_ctrl_pkg;

  localparam int DEF_RAM_DEPTH  = 1024;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_AF_THRESH  = 1020;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

endpackage

// File: rtl/tx_fifo_ptr.sv
// RAM pointer that wraps at DEPTH-1 (depth need not be a power of two).
module tx_fifo_ptr #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] ptr_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      ptr_reg <= '0;
    end else if (i_inc) begin
      ptr_reg <= (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    end
  end

  assign o_ptr = ptr_reg;

endmodule

// File: rtl/tx_fifo_ctrl.sv
// TX FIFO controller: sequences an external dp_ram and registers read data
// into a valid/ready output stage.
module tx_fifo_ctrl
  import tx_fifo_ctrl_pkg::*;
#(
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [ADDR_WIDTH-1:0] o_ram_waddr,
  output logic                  o_ram_wen,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic [ADDR_WIDTH-1:0] o_ram_raddr,
  output logic                  o_ram_ren,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  out_state_e            state_reg, state_next;
  logic [CNT_W-1:0]      ram_cnt_reg, ram_cnt_next;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic                  wr, load;

  // Ready looks only at the registered count, so a same-cycle load never
  // opens a slot for a write while full.
  assign o_s_ready = (ram_cnt_reg < CNT_W'(RAM_DEPTH)) && !i_flush;
  assign wr        = i_rst_n && i_s_valid && o_s_ready;
  assign load      = i_rst_n && ((state_reg == OUT_EMPTY) || i_m_ready)
                     && (ram_cnt_reg != '0) && !i_flush;

  always_comb begin
    state_next   = state_reg;
    ram_cnt_next = ram_cnt_reg;
    case (state_reg)
      OUT_EMPTY: if (load) state_next = OUT_HOLD;
      OUT_HOLD:  if (i_m_ready && !load) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
    if (wr && !load) begin
      ram_cnt_next = ram_cnt_reg + 1'b1;
    end else if (load && !wr) begin
      ram_cnt_next = ram_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= OUT_EMPTY;
      ram_cnt_reg <= '0;
      m_data_reg  <= '0;
    end else if (i_flush) begin
      // Flush keeps the last output word; only valid is dropped.
      state_reg   <= OUT_EMPTY;
      ram_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ram_cnt_reg <= ram_cnt_next;
      if (load) m_data_reg <= i_ram_rdata;
    end
  end

  tx_fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)) u_wptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_inc   (wr),
    .o_ptr   (o_ram_waddr)
  );

  tx_fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)) u_rptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_inc   (load),
    .o_ptr   (o_ram_raddr)
  );

  assign o_ram_wen     = wr;
  assign o_ram_wdata   = i_s_data;
  assign o_ram_ren     = load;
  assign o_m_valid     = (state_reg == OUT_HOLD);
  assign o_m_data      = m_data_reg;
  assign o_level       = ram_cnt_reg + CNT_W'(o_m_valid);
  assign o_empty       = (o_level == '0);
  assign o_full        = (ram_cnt_reg == CNT_W'(RAM_DEPTH));
  assign o_almost_full = (o_level >= CNT_W'(AF_THRESH));

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Bench for tx_fifo_ctrl with a small behavioural dp_ram (depth 5).
module tb_tx_fifo_ctrl;

  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int AF    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, s_valid, s_ready, m_valid, m_ready;
  logic          ram_wen, ram_ren, empty, full, afull;
  logic [DW-1:0] s_data, m_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW:0]   level;

  tx_fifo_ctrl #(
    .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_ram_waddr(ram_waddr), .o_ram_wen(ram_wen), .o_ram_wdata(ram_wdata),
    .o_ram_raddr(ram_raddr), .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata),
    .o_level(level), .o_empty(empty), .o_full(full), .o_almost_full(afull)
  );

  // dp_ram stand-in: synchronous write, combinational read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_wen && int'(ram_waddr) < DEPTH) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = (int'(ram_raddr) < DEPTH) ? mem[ram_raddr] : '0;

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  logic [DW-1:0] sb[$];

  // Reference model: FIFO occupancy, output-register flag and write/read totals
  int m_cnt  = 0;
  bit m_outv = 1'b0;
  int m_wtot = 0;
  int m_rtot = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every downstream handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      hs_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %02h expected no word", m_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        $display("[TB] out word %02h (expect %02h)", m_data, e);
        chk("out_data", 32'(m_data), 32'(e));
      end
    end
  end

  task automatic cycle(input bit rn, input bit v, input logic [DW-1:0] d,
                       input bit mr, input bit fl);
    bit e_ready, e_wr, e_load;
    int lvl;
    rst_n = rn; s_valid = v; s_data = d; m_ready = mr; flush = fl;
    #1;
    lvl     = m_cnt + int'(m_outv);
    e_ready = (m_cnt < DEPTH) && !fl;
    e_wr    = rn && v && e_ready;
    e_load  = rn && (!m_outv || mr) && (m_cnt != 0) && !fl;
    chk("s_ready", 32'(s_ready), 32'(e_ready));
    chk("level", 32'(level), lvl);
    chk("empty", 32'(empty), 32'(lvl == 0));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("almost_full", 32'(afull), 32'(lvl >= AF));
    chk("m_valid", 32'(m_valid), 32'(m_outv));
    chk("ram_wen", 32'(ram_wen), 32'(e_wr));
    chk("ram_ren", 32'(ram_ren), 32'(e_load));
    if (e_wr) begin
      chk("ram_waddr", 32'(ram_waddr), m_wtot % DEPTH);
      sb.push_back(d);
    end
    if (e_load) chk("ram_raddr", 32'(ram_raddr), m_rtot % DEPTH);
    @(posedge clk);
    if (!rn || fl) begin
      m_cnt = 0; m_outv = 1'b0; m_wtot = 0; m_rtot = 0;
      sb.delete();
    end else begin
      if (e_wr) begin m_cnt++; m_wtot++; end
      if (e_load) begin m_cnt--; m_rtot++; m_outv = 1'b1; end
      else if (m_outv && mr) m_outv = 1'b0;
    end
    #1;
  endtask

  initial begin
    int nd, hs0;
    bit v, mr, pre_ready;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 8'hFF; m_ready = 1'b0;
    @(posedge clk); #1;

    // reset held with valid high: nothing written
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // single-word latency
    cycle(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // fill with stalled output: 6 accepted, 0x07 rejected
    for (int d = 1; d <= 7; d++) cycle(1'b1, 1'b1, 8'(d), 1'b0, 1'b0);
    chk("fill_level", 32'(level), 6);
    chk("fill_full", 32'(full), 1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // randomized stream 0x00..0x13 through the wrapping pointers
    nd = 0;
    for (int i = 0; i < 400 && nd < 20; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      mr = 1'($urandom_range(0, 1));
      pre_ready = (m_cnt < DEPTH);
      cycle(1'b1, v, 8'(nd), mr, 1'b0);
      if (v && pre_ready) nd++;
    end
    chk("stream_count", 32'(nd), 20);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", 32'(sb.size()), 0);

    // simultaneous write and pop at level 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk("simul_level", 32'(level), 3);
    end
    chk("simul_throughput", 32'(hs_count - hs0), 10);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // flush at level 6 with a write offered in the same cycle
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("preflush_level", 32'(level), 6);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("flush_level", 32'(level), 0);
    chk("flush_m_valid", 32'(m_valid), 0);
    cycle(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
